// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: forward key expansion to round key 10, then
// one decryption round per clock while the inverse key schedule walks back to round key 0.
module inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] in,
    input  logic [0:127] key,
    output logic [0:127] out,
    output logic         busy,
    output logic         done
);

    if (Nk != 4 || Nr != 10) begin : g_param_err
        $error("inv_cipher supports only Nk=4 and Nr=10");
    end

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Undoes xtime: an odd value can only come from a reduced (high-bit) input.
    function automatic logic [7:0] xtime_inv(input logic [7:0] a);
        return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] sq;
        p  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 0, 0, 0}
    function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rc);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]) ^ rc, sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [0:127] st_q, st_d;
    logic [0:127] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [0:127] out_q, out_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // ------------------------------------------------------------------
    // Key schedule, forward and inverse, both driven by rcon_q
    // ------------------------------------------------------------------
    logic [31:0]  kw [4];
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [31:0]  iw0, iw1, iw2, iw3;
    logic [0:127] rk_fwd;
    logic [0:127] rk_inv;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_kw
        assign kw[gi] = rk_q[32*gi +: 32];
    end

    assign fw0    = kw[0] ^ key_f(kw[3], rcon_q);
    assign fw1    = kw[1] ^ fw0;
    assign fw2    = kw[2] ^ fw1;
    assign fw3    = kw[3] ^ fw2;
    assign rk_fwd = {fw0, fw1, fw2, fw3};

    assign iw3    = kw[3] ^ kw[2];
    assign iw2    = kw[2] ^ kw[1];
    assign iw1    = kw[1] ^ kw[0];
    assign iw0    = kw[0] ^ key_f(iw3, rcon_q);
    assign rk_inv = {iw0, iw1, iw2, iw3};

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    // Byte n of the state sits at row n%4, column n/4.
    // ------------------------------------------------------------------
    logic [0:127] t;
    logic [0:127] imc;

    for (gi = 0; gi < 16; gi++) begin : g_isr
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign t[8*gi +: 8] = inv_sbox(st_q[8*SRC +: 8]) ^ rk_inv[8*gi +: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = t[32*gi      +: 8];
        assign a1 = t[32*gi + 8  +: 8];
        assign a2 = t[32*gi + 16 +: 8];
        assign a3 = t[32*gi + 24 +: 8];
        assign imc[32*gi      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign imc[32*gi + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign imc[32*gi + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign imc[32*gi + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    st_d    = in;
                    rk_d    = key;
                    rcon_d  = 8'h01;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d   = rk_fwd;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    // Initial AddRoundKey with round key 10 as it is produced.
                    st_d    = st_q ^ rk_fwd;
                    rcon_d  = 8'h36;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // cnt_q holds r+1; rk_q holds rk_{r+1}; rcon_q is the rcon of round r+1.
                rk_d   = rk_inv;
                rcon_d = xtime_inv(rcon_q);
                cnt_d  = cnt_q - 4'd1;
                st_d   = imc;
                if (cnt_q == 4'd1) begin
                    st_d    = t;
                    out_d   = t;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rcon_q  <= 8'h00;
            cnt_q   <= 4'd0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed and random bench for inv_cipher: FIPS vectors, timing, restart/ignore/abort
// behaviour and a round trip through a behavioural forward AES-128 model.
module tb_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [0:127] in_v = '0;
    logic [0:127] key_v = '0;
    logic [0:127] out_v;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    inv_cipher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_v),
        .key   (key_v),
        .out   (out_v),
        .busy  (busy),
        .done  (done)
    );

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb_t [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding plaintext.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) check("unexpected done", 128'd1, 128'd0);
            else check("scoreboard out", out_v, exp_q.pop_front());
        end
    end

    // ---------------- behavioural forward AES-128 ----------------
    function automatic logic [7:0] m2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = m2(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8];
            sb_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   w [16];
        logic [7:0]   u [16];
        logic [7:0]   rc = 8'h01;
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] r;
        for (int n = 0; n < 16; n++) begin
            s[n] = p[127-8*n -: 8] ^ k[127-8*n -: 8];
            w[n] = k[127-8*n -: 8];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t0 = sb_t[w[13]] ^ rc; t1 = sb_t[w[14]]; t2 = sb_t[w[15]]; t3 = sb_t[w[12]];
            w[0] ^= t0; w[1] ^= t1; w[2] ^= t2; w[3] ^= t3;
            for (int i = 4; i < 16; i++) w[i] ^= w[i-4];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    u[4*c+rr] = sb_t[s[4*((c+rr)%4)+rr]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = m2(u[4*c]) ^ m2(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+1] = u[4*c] ^ m2(u[4*c+1]) ^ m2(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+2] = u[4*c] ^ u[4*c+1] ^ m2(u[4*c+2]) ^ m2(u[4*c+3]) ^ u[4*c+3];
                    s[4*c+3] = m2(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ m2(u[4*c+3]);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = u[4*c+rr];
                end
            end
            for (int n = 0; n < 16; n++) s[n] ^= w[n];
            rc = m2(rc);
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [127:0] k, input logic [127:0] c,
                          input logic [127:0] p, input bit push);
        start = 1'b1;
        in_v  = c;
        key_v = k;
        if (push) exp_q.push_back(p);
        @(negedge clk);
        start = 1'b0;
        in_v  = rnd128();
        key_v = rnd128();
    endtask

    // k counts edges since acceptance; bh counts busy-high samples before done.
    task automatic wait_done(input int k0, output int k, output int bh);
        k  = k0;
        bh = k0;
        while (!done && k < 40) begin
            if (busy) bh++;
            @(negedge clk);
            k++;
        end
        if (!done) check("done timeout", 128'd0, 128'd1);
    endtask

    initial begin
        int k, bh, cyc1, cyc2, dones;
        logic [127:0] rk, pt;
        build_sbox();

        repeat (2) @(negedge clk);
        check("reset out", out_v, 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector C.1: latency, busy window and pulse width
        launch(K1, C1, P1, 1'b1);
        wait_done(0, k, bh);
        check("C1 latency", 128'(k), 128'd20);
        check("C1 busy cycles", 128'(bh), 128'd20);
        check("C1 busy at done", 128'(busy), 128'd0);
        check("C1 out", out_v, P1);
        @(negedge clk);
        check("C1 done width", 128'(done), 128'd0);
        check("C1 out hold", out_v, P1);

        // Vector B with round key 10 inspection
        launch(K2, C2, P2, 1'b1);
        repeat (10) @(negedge clk);
        rk = dut.rk_q;
        check("B rk10", rk, RKA);
        check("B out not modified mid-run", out_v, P1);
        wait_done(10, k, bh);
        check("B latency", 128'(k), 128'd20);

        // Zero key
        @(negedge clk);
        launch(128'd0, CZ, 128'd0, 1'b1);
        wait_done(0, k, bh);

        // Back-to-back restart in the done cycle
        @(negedge clk);
        launch(K1, C1, P1, 1'b1);
        wait_done(0, k, bh);
        cyc1 = cyc;
        launch(K2, C2, P2, 1'b1);
        wait_done(0, k, bh);
        cyc2 = cyc;
        check("b2b done spacing", 128'(cyc2 - cyc1), 128'd21);

        // Start pulse at E5 of a running block is ignored
        @(negedge clk);
        launch(K1, C1, P1, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        in_v  = C2;
        key_v = K2;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, k, bh);
        check("ignored start latency", 128'(k), 128'd20);
        @(negedge clk);
        check("ignored start no second done", 128'(done), 128'd0);

        // Reset mid-operation
        launch(K2, C2, P2, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out", out_v, 128'd0);
        check("abort busy", 128'(busy), 128'd0);
        check("abort done", 128'(done), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort no activity", 128'(dones), 128'd0);
        launch(K1, C1, P1, 1'b1);
        wait_done(0, k, bh);
        check("post-abort latency", 128'(k), 128'd20);

        // Round trip through the forward model
        for (int i = 0; i < 100; i++) begin
            rk = rnd128();
            pt = rnd128();
            @(negedge clk);
            launch(rk, aes_enc(rk, pt), pt, 1'b1);
            wait_done(0, k, bh);
        end

        repeat (2) @(negedge clk);
        check("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inv_cipher.md
Name: inv_cipher

Overview:
Iterative AES-128 inverse cipher (FIPS-197 §5.3). It decrypts one 128-bit block per request, one round per clock.
- Companion to the forward `cipher` block; `cipher` output fed to `inv_cipher` with the same key must return the original plaintext.
- Round keys are derived on the fly: a forward key expansion reaches round key 10, then the inverse key schedule walks back down while decrypting. No key RAM.

Parameters:
Nk, 4, key length in 32-bit words; only 4 supported, any other value is an elaboration error
Nr, 10, number of rounds; only 10 supported, any other value is an elaboration error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
in  input  [0:127]  ciphertext; bit 0 = MSB of byte 0 (FIPS byte order); must be valid only at the accepting edge
key  input  [0:127]  cipher key, same ordering; must be valid only at the accepting edge
out  output  [0:127]  plaintext register
busy  output  1  high while a block is in progress
done  output  1  one-cycle pulse when out is updated

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, busy=0, done=0; internal state, round-key and rcon registers cleared.
- States: IDLE, KEYEXP, ROUND.
- IDLE:
  - start=1 at edge E0: latch in→st, key→rk.
  - Set rcon=0x01, cnt=0, busy=1, next state KEYEXP.
  - start=0: remain in IDLE.
- KEYEXP (edges E1..E10):
  - Each edge: rk ← forward expansion of rk using SubWord(RotWord(w3))^rcon; rcon ← xtime(rcon); cnt++.
  - At E10 (cnt=9→10) also: st ← st ^ rk10 (the combinational next-rk value); rcon ← 0x36; state ← ROUND.
- ROUND (edges E11..E20), round index r = 9 down to 0:
  - rk_r = inverse schedule of rk_{r+1}: w[i-4] = w[i] ^ f(w[i-1]), with f using forward S-box, RotWord, and the rcon of round r+1.
  - Datapath: t = InvSubBytes(InvShiftRows(st)) ^ rk_r.
  - st ← InvMixColumns(t) for r>0; t is used as-is for r=0.
  - rcon steps down each edge: 0x36, 0x1b, 0x80, 0x40, …, 0x01 (inverse xtime or table lookup).
  - At E20 (r=0): out ← t, done ← 1, busy ← 0, state ← IDLE.
- Latency:
  - done is high in the cycle after E20, i.e. 20 clocks after the accepting edge.
  - Throughput is one block per 21 clocks: a start sampled while done=1 is accepted, because state is already IDLE.
- done is exactly one cycle wide; it deasserts at the next edge regardless of start.
- out holds its value until the next completion. It is not cleared on start and is not modified mid-operation.
- start while busy=1 is ignored: no queueing, and in/key changes have no effect.
- Reset asserted mid-operation: immediate return to reset values; no done pulse; the aborted block is lost.
- No X propagation: every register has a reset value; in/key are used only at the accepting edge.
- Arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are {0e,0b,0d,09}.

Test Plan:
1. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a, start 1 cycle → after 20 clocks done=1, out=00112233445566778899aabbccddeeff; busy high for exactly those 20 cycles.
2. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 → out=3243f6a8885a308d313198a2e0370734. Also check the internal rk after E10 equals d014f9a8c9ee2589e13f0cc8b6630ca6.
3. Zero key: key 0, in 66e94bd4ef8a2c3b884cfa59ca342b2e → out=0.
4. Back-to-back and ignored start: restart in the done cycle with vector 2 → accepted, second done 21 clocks after the first. Pulse start at E5 of a running block with different in/key → ignored, result unchanged.
5. Reset mid-operation: assert rst_n=0 at E7 → out=0, busy=0, no done. A fresh run of vector 1 after release → correct result.
6. Round trip: 100 random key/plaintext pairs through `cipher`, its output fed to `inv_cipher` with the same key → out equals the original plaintext every time.
